// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative radix-2 SRT IEEE-754 divider with run-time rounding, back-pressure and abort
module fp_div_iter #(
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int NITER = MW + 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [EW+MW:0] a,
  input  logic [EW+MW:0] b,
  input  logic [2:0]     rm,
  input  logic           kill,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [EW+MW:0] out_result,
  output logic [4:0]     out_flags,
  output logic           busy
);
  localparam int PW = MW + 3;
  localparam int CW = $clog2(NITER + 1);
  localparam logic [EW+1:0] BIAS = {3'b000, {(EW-1){1'b1}}};
  localparam logic [EW+1:0] EMAX = {2'b00, {EW{1'b1}}};
  localparam logic [2:0] RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011, RMM = 3'b100;
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] p, d2, p2, p_next, p_fix;
  logic [NITER-1:0] qp, qn, q;
  logic [EW+1:0] e, exp_n, exp_r;
  logic [2:0] rm_q;
  logic sign, dz;
  logic sa, sb;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] fa, fb;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, nan_out, special;
  logic [EW+MW:0] spec_res, fix_res;
  logic [4:0] spec_flags, fix_flags;
  logic [MW:0] mant;
  logic [MW+1:0] mant_r;
  logic msb, g, r, st, inexact, up, ovf, unf, to_inf;
  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign a_nan = &ea & |fa;
  assign b_nan = &eb & |fb;
  assign a_snan = a_nan & ~fa[MW-1];
  assign b_snan = b_nan & ~fb[MW-1];
  assign a_inf = &ea & ~|fa;
  assign b_inf = &eb & ~|fb;
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign nan_out = a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero);
  assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  always_comb begin
    spec_res = nan_out ? {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}}
             : (a_inf | b_zero) ? {sa ^ sb, {EW{1'b1}}, {MW{1'b0}}}
             : {sa ^ sb, {(EW+MW){1'b0}}};
    spec_flags = nan_out ? {a_snan | b_snan | ~(a_nan | b_nan), 4'b0000}
               : {1'b0, b_zero & ~a_inf, 3'b000};
  end
  // p holds the remainder in units where the divisor reads as 2*mb; digit 0 keeps |p| below the divisor
  assign p2 = {p[PW-2:0], 1'b0};
  assign dz = (p[PW-1:PW-3] == 3'b000) | (p[PW-1:PW-3] == 3'b111);
  assign p_next = dz ? p2 : p[PW-1] ? p2 + d2 : p2 - d2;
  always_comb begin
    q = qp - qn - {{(NITER-1){1'b0}}, p[PW-1]};
    p_fix = p[PW-1] ? p + d2 : p;
    st = |p_fix;
    msb = q[NITER-1];
    mant = msb ? q[NITER-1:2] : q[NITER-2:1];
    g = msb ? q[1] : q[0];
    r = msb & q[0];
    inexact = g | r | st;
    up = rm_q == RTZ ? 1'b0 : rm_q == RDN ? sign & inexact : rm_q == RUP ? ~sign & inexact
       : rm_q == RMM ? g : g & (r | st | mant[0]);
    mant_r = {1'b0, mant} + {{(MW+1){1'b0}}, up};
    exp_n = msb ? e : e - {{(EW+1){1'b0}}, 1'b1};
    exp_r = exp_n + {{(EW+1){1'b0}}, mant_r[MW+1]};
    ovf = $signed(exp_r) >= $signed(EMAX);
    unf = ~ovf & (exp_r[EW+1] | ~|exp_r);
    to_inf = rm_q == RTZ ? 1'b0 : rm_q == RDN ? sign : rm_q == RUP ? ~sign : 1'b1;
    fix_res = ovf ? (to_inf ? {sign, {EW{1'b1}}, {MW{1'b0}}} : {sign, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}})
            : unf ? {sign, {(EW+MW){1'b0}}} : {sign, exp_r[EW-1:0], mant_r[MW-1:0]};
    fix_flags = {2'b00, ovf, unf, inexact | ovf | unf};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      out_result <= '0;
      out_flags <= '0;
      cnt <= '0;
    end else if (kill && state != IDLE) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign <= sa ^ sb;
          rm_q <= rm;
          e <= {2'b00, ea} - {2'b00, eb} + BIAS;
          p <= {2'b00, 1'b1, fa};
          d2 <= {1'b0, 1'b1, fb, 1'b0};
          qp <= '0;
          qn <= '0;
          cnt <= '0;
          in_ready <= 1'b0;
          busy <= 1'b1;
          state <= special ? DONE : ITER;
          out_valid <= special;
          if (special) begin
            out_result <= spec_res;
            out_flags <= spec_flags;
          end
        end
        ITER: begin
          p <= p_next;
          qp <= {qp[NITER-2:0], ~dz & ~p[PW-1]};
          qn <= {qn[NITER-2:0], ~dz & p[PW-1]};
          cnt <= cnt + CW'(1);
          if (cnt == CW'(NITER - 1)) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          cnt <= '0;
          out_valid <= 1'b1;
          out_result <= fix_res;
          out_flags <= fix_flags;
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_iter.sv
// tb_fp_div_iter: directed self-checking bench for the iterative FP divider (single and double)
module tb_fp_div_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, in_valid, kill, out_ready, in_ready, out_valid, busy;
  logic [31:0] a, b, out_result;
  logic [2:0] rm;
  logic [4:0] out_flags;
  logic in_valid_d, in_ready_d, out_valid_d, busy_d;
  logic [63:0] a_d, b_d, out_result_d;
  logic [4:0] out_flags_d;
  int errors = 0;
  int checks = 0;

  fp_div_iter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .rm(rm),
    .kill(kill), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .busy(busy)
  );

  fp_div_iter #(.EW(11), .MW(52)) dut_d (
    .clk(clk), .reset(reset), .in_valid(in_valid_d), .in_ready(in_ready_d), .a(a_d), .b(b_d), .rm(rm),
    .kill(kill), .out_valid(out_valid_d), .out_ready(out_ready), .out_result(out_result_d),
    .out_flags(out_flags_d), .busy(busy_d)
  );

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] rmv,
                       output logic [31:0] res, output logic [4:0] fl, output int lat);
    @(negedge clk);
    a = av; b = bv; rm = rmv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL timeout: no out_valid for %h/%h after %0d cycles", av, bv, lat);
    end
    res = out_result; fl = out_flags;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
    checks++;
    if (out_result !== 32'h0 || out_flags !== 5'h0) begin
      errors++;
      $display("FAIL reset_data: result=%h flags=%b, want 0 0", out_result, out_flags);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] res; logic [4:0] fl; int lat;
    do_op(32'h40C00000, 32'h40000000, 3'b000, res, fl, lat);
    checks++;
    if (res !== 32'h40400000) begin errors++; $display("FAIL basic_result: got %h want 40400000", res); end
    checks++;
    if (fl !== 5'b00000) begin errors++; $display("FAIL basic_flags: got %b want 00000", fl); end
    checks++;
    if (lat !== 28) begin errors++; $display("FAIL basic_latency: got %0d want 28", lat); end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_in_ready: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] ta [6] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'hBF800000, 32'h3F800000};
    logic [2:0]  tr [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b011, 3'b100};
    logic [31:0] te [6] = '{32'h3EAAAAAB, 32'h3EAAAAAA, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'hBEAAAAAA, 32'h3EAAAAAB};
    logic [31:0] res; logic [4:0] fl; int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], 32'h40400000, tr[i], res, fl, lat);
      checks++;
      if (res !== te[i] || fl !== 5'b00001) begin
        errors++;
        $display("FAIL round_%0d: got %h/%b want %h/00001", i, res, fl, te[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] ta [4] = '{32'h3F800000, 32'h00000000, 32'h7F800001, 32'hFF800000};
    logic [31:0] tb [4] = '{32'h00000000, 32'h00000000, 32'h3F800000, 32'h40000000};
    logic [31:0] te [4] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000};
    logic [4:0]  tf [4] = '{5'b01000, 5'b10000, 5'b10000, 5'b00000};
    logic [31:0] res; logic [4:0] fl; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], 3'b000, res, fl, lat);
      checks++;
      if (res !== te[i] || fl !== tf[i] || lat !== 1) begin
        errors++;
        $display("FAIL special_%0d: got %h/%b lat %0d want %h/%b lat 1", i, res, fl, lat, te[i], tf[i]);
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] res; logic [4:0] fl; int lat;
    do_op(32'h7F7FFFFF, 32'h3E800000, 3'b000, res, fl, lat);
    checks++;
    if (res !== 32'h7F800000 || fl !== 5'b00101) begin
      errors++; $display("FAIL overflow_rne: got %h/%b want 7f800000/00101", res, fl);
    end
    do_op(32'h7F7FFFFF, 32'h3E800000, 3'b001, res, fl, lat);
    checks++;
    if (res !== 32'h7F7FFFFF || fl !== 5'b00101) begin
      errors++; $display("FAIL overflow_rtz: got %h/%b want 7f7fffff/00101", res, fl);
    end
    do_op(32'h00800000, 32'h40000000, 3'b000, res, fl, lat);
    checks++;
    if (res !== 32'h00000000 || fl !== 5'b00011) begin
      errors++; $display("FAIL underflow: got %h/%b want 00000000/00011", res, fl);
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; rm = 3'b000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'h40400000 || out_flags !== 5'b0) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b result=%h flags=%b want 1 40400000 00000", i, out_valid, out_result, out_flags);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_kill();
    logic [31:0] res; logic [4:0] fl; int lat;
    logic seen;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; rm = 3'b000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL kill_idle: valid=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL kill_no_result: out_valid seen=%b want 0", seen); end
    do_op(32'h40C00000, 32'h40000000, 3'b000, res, fl, lat);
    checks++;
    if (res !== 32'h40400000 || fl !== 5'b0 || lat !== 28) begin
      errors++; $display("FAIL after_kill: got %h/%b lat %0d want 40400000/00000 lat 28", res, fl, lat);
    end
    @(negedge clk);
    a = 32'h3F800000; b = 32'h00000000; in_valid = 1'b1; kill = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h7F800000) begin
      errors++; $display("FAIL kill_accept: valid=%b result=%h want 1 7f800000", out_valid, out_result);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 || out_flags !== 5'h0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b in_ready=%b result=%h flags=%b want 0 0 1 0 0",
               out_valid, busy, in_ready, out_result, out_flags);
    end
  endtask

  task automatic test_double();
    int lat;
    @(negedge clk);
    a_d = 64'h4018000000000000; b_d = 64'h4000000000000000; rm = 3'b000; in_valid_d = 1'b1;
    @(negedge clk);
    in_valid_d = 1'b0;
    lat = 1;
    while (!out_valid_d && lat < 200) begin @(negedge clk); lat++; end
    checks++;
    if (out_result_d !== 64'h4008000000000000 || out_flags_d !== 5'b0) begin
      errors++; $display("FAIL double_result: got %h/%b want 4008000000000000/00000", out_result_d, out_flags_d);
    end
    checks++;
    if (lat !== 57) begin errors++; $display("FAIL double_latency: got %0d want 57", lat); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_valid_d = 1'b0; kill = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; a_d = '0; b_d = '0; rm = 3'b000;
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_range();
    test_backpressure();
    test_kill();
    test_double();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
